// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: opcode/funct decode
// values, FSM state type and a conditional-negate helper.
package ex_muldiv_pkg;

  localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [6:0] FUNCT7_M      = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'd0;
  localparam logic [2:0] INST_MULH   = 3'd1;
  localparam logic [2:0] INST_MULHSU = 3'd2;
  localparam logic [2:0] INST_MULHU  = 3'd3;
  localparam logic [2:0] INST_DIV    = 3'd4;
  localparam logic [2:0] INST_DIVU   = 3'd5;
  localparam logic [2:0] INST_REM    = 3'd6;
  localparam logic [2:0] INST_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_core.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// Exposes the post-step quotient/remainder so the caller can register the final result.
module div_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_nxt_o,
  output logic [31:0] rem_nxt_o
);

  logic [31:0] quo_q, rem_q, dvs_q;
  logic [31:0] quo_d, rem_d, dvs_d;
  logic [32:0] trial;

  // Partial remainder stays below the divisor, so {rem, next bit} fits 33 bits
  // and bit 32 of the trial difference is a clean borrow flag.
  always_comb begin
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (trial[32]) begin
      rem_nxt_o = {rem_q[30:0], quo_q[31]};
      quo_nxt_o = {quo_q[30:0], 1'b0};
    end else begin
      rem_nxt_o = trial[31:0];
      quo_nxt_o = {quo_q[30:0], 1'b1};
    end
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (step_i) begin
      quo_d = quo_nxt_o;
      rem_d = rem_nxt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit (MUL*/DIV*/REM*) with pipeline stall request.
// Define MULDIV_FAST_MUL_EN for a single-cycle 33x33 multiplier; division stays iterative.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [4:0]  rd_addr,
  input  logic        flush,
  output logic        stall_req,
  output logic [31:0] md_rd_data,
  output logic [4:0]  md_rd_addr,
  output logic        md_rd_wen
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        neg_q, rneg_q;
  logic [63:0] acc_q;
  logic [31:0] mcand_q;
  logic [31:0] data_q;
  logic [4:0]  addr_q;
  logic        wen_q;

  logic        start, accept, is_div, sgn1, sgn2, s1, s2;
  logic        div_zero, div_ovf;
  logic [2:0]  f3;
  logic [31:0] a_mag, b_mag, special_res;
  logic [32:0] msum;
  logic [63:0] acc_step, prod;
  logic [31:0] quo_nxt, rem_nxt, final_res;
  logic        unused_inst;

  assign f3          = inst[14:12];
  assign start       = (inst[6:0] == INST_TYPE_R_M) && (inst[31:25] == FUNCT7_M);
  assign accept      = (state_q == ST_IDLE) && start && !flush;
  assign unused_inst = ^{inst[24:15], inst[11:7]};

  assign is_div = f3[2];
  assign sgn1   = is_div ? !f3[0] : (f3 != INST_MULHU);
  assign sgn2   = is_div ? !f3[0] : (f3[2:1] == 2'b00);
  assign s1     = sgn1 & op1[31];
  assign s2     = sgn2 & op2[31];
  assign a_mag  = cneg32(op1, s1);
  assign b_mag  = cneg32(op2, s2);

  assign div_zero    = is_div && (op2 == '0);
  assign div_ovf     = is_div && !f3[0] && (op1 == 32'h8000_0000) && (op2 == '1);
  assign special_res = div_zero ? (f3[1] ? op1 : '1) : (f3[1] ? '0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [32:0] fa, fb;
  logic signed [63:0] fprod;
  logic [31:0]        fast_res;
  assign fa       = {s1, op1};
  assign fb       = {s2, op2};
  assign fprod    = 64'(fa) * 64'(fb);
  assign fast_res = (f3 == INST_MUL) ? fprod[31:0] : fprod[63:32];
`endif

  // Shift-add on magnitudes: multiplier bits are consumed from acc_q[31:0]
  // while the partial sum enters from the top; sign is applied at the end.
  assign msum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
  assign acc_step = {msum, acc_q[31:1]};
  assign prod     = neg_q ? (64'd0 - acc_step) : acc_step;

  div_core u_div_core (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .load_i     (accept),
    .step_i     ((state_q == ST_BUSY) && !flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    final_res = '0;
    if (f3_q[2]) final_res = f3_q[1] ? cneg32(rem_nxt, rneg_q) : cneg32(quo_nxt, neg_q);
    else         final_res = (f3_q == INST_MUL) ? prod[31:0] : prod[63:32];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      if (flush) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: if (start) begin
            f3_q    <= f3;
            rd_q    <= rd_addr;
            neg_q   <= s1 ^ s2;
            rneg_q  <= s1;
            acc_q   <= {32'd0, b_mag};
            mcand_q <= a_mag;
            cnt_q   <= '0;
            if (div_zero || div_ovf) begin
              state_q <= ST_DONE;
              data_q  <= special_res;
              addr_q  <= rd_addr;
              wen_q   <= (rd_addr != '0);
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              state_q <= ST_DONE;
              data_q  <= fast_res;
              addr_q  <= rd_addr;
              wen_q   <= (rd_addr != '0);
`endif
            end else begin
              state_q <= ST_BUSY;
            end
          end
          ST_BUSY: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= ST_DONE;
              data_q  <= final_res;
              addr_q  <= rd_q;
              wen_q   <= (rd_q != '0);
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign stall_req  = sys_rst_n && (accept || (state_q == ST_BUSY));
  assign md_rd_data = data_q;
  assign md_rd_addr = addr_q;
  assign md_rd_wen  = wen_q && !flush;

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

- Multi-cycle RV32M unit in the execute stage: consumes the instruction and operands registered by the ID/EX pipeline register and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Latches operands on accept and raises a stall request so the pipeline controller freezes PC, IF/ID and ID/EX until the result is ready.
- Delivers a one-cycle register-file write (address, data, enable) alongside the ALU write path, which is muxed by the execute stage.

## Interface
- No parameters.
- sys_clk  in  1  single clock, rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- inst  in  32  instruction from ID/EX (`inst_dly`)
- op1  in  32  rs1 value from ID/EX
- op2  in  32  rs2 value from ID/EX
- rd_addr  in  5  destination register from ID/EX
- flush  in  1  jump/branch taken in EX; aborts any operation
- stall_req  out  1  to pipeline controller; freeze upstream while high
- md_rd_data  out  32  result
- md_rd_addr  out  5  destination register
- md_rd_wen  out  1  one-cycle write enable

## Operation
- Start decode:
  - `start` = opcode 7'b0110011 and funct7 7'b0000001; funct3 selects the op.
  - Non-M instructions are ignored.
- States:
  - IDLE: accepts on `start & !flush`.
    - Latches funct3, rd_addr and operand magnitudes/signs.
    - Goes to BUSY, or to DONE directly for special cases.
  - BUSY: iterates; 5-bit counter counts 0..31; after iteration 31, goes to DONE.
  - DONE: result registered; md_rd_wen=1 for exactly this cycle; returns to IDLE next edge.
- stall_req = (IDLE & start & !flush) | BUSY.
  - stall_req is combinational so the freeze covers the accept cycle.
  - stall_req is low in DONE, so the pipeline advances at the end of DONE.
  - `start` is ignored in DONE: the same instruction is still in ID/EX.
- Multiply:
  - Operands are sign/zero-extended to 33 bits per op.
  - Radix-2 shift-add over 32 iterations into a 64-bit product; the sign is fixed at DONE.
  - MUL returns bits[31:0]; MULH/MULHSU/MULHU return bits[63:32].
- Divide: restoring, 32 iterations on magnitudes. Quotient sign = sign(op1) xor sign(op2), signed ops only. Remainder sign = sign(op1).
- Special cases: one cycle, go IDLE→DONE with no BUSY.
  - Divisor 0: quotient 32'hFFFFFFFF, remainder = op1, for signed and unsigned.
  - DIV/REM of 32'h80000000 by 32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
- md_rd_wen = DONE & (latched rd_addr != 0).
- flush in any state:
  - Next state is IDLE; no write; counter cleared.
  - Flush while in DONE suppresses md_rd_wen in that cycle.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - md_rd_data 0, md_rd_addr 0, md_rd_wen 0, stall_req 0.
  - All operand/accumulator registers 0.
- Accept edge E0; BUSY spans E1..E32; DONE is the cycle after E32, i.e. a 33-cycle stall, then 1 writeback cycle.
- Special case: DONE is the cycle after E0.
- Reset asserted mid-operation: immediately IDLE, outputs at reset values, no write after release.
- Back-to-back M instructions: the second is accepted in IDLE no earlier than the cycle after DONE.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL* uses a single-cycle 33x33 signed combinational multiplier.
  - Accept goes IDLE→DONE (1-cycle stall).
  - Division is unchanged.
- Not defined: iterative shift-add multiply as above (33-cycle stall).

## Structure
- Shared defines file holds:
  - `INST_TYPE_R_M` opcode and `FUNCT7_M` 7'b0000001.
  - Eight funct3 constants: `INST_MUL`..`INST_REMU`.
  - State encodings for IDLE/BUSY/DONE.
- Sub-module `div_core`: restoring divider iteration (remainder/quotient shift registers, 32-bit subtract).
- FSM, sign handling, special cases and the multiplier stay in ex_muldiv.

## Test plan
- MUL 7 × -3, rd=x5:
  - stall_req high for 33 cycles, then md_rd_wen=1 for one cycle.
  - md_rd_data=32'hFFFFFFEB, md_rd_addr=5.
  - With the macro, stall is 1 cycle.
- MULHU 32'hFFFFFFFF × 32'hFFFFFFFF → 32'hFFFFFFFE. MULHSU 32'hFFFFFFFF × 32'hFFFFFFFF → 32'hFFFFFFFF.
- DIV -7 / 2 → 32'hFFFFFFFD; REM -7 % 2 → 32'hFFFFFFFF; REMU 100 % 7 → 2. Each has a 33-cycle stall.
- DIVU 5/0 → 32'hFFFFFFFF and REM 5%0 → 5, with a 1-cycle stall. DIV 32'h80000000 / -1 → 32'h80000000.
- flush at iteration 10 of a DIV: IDLE next cycle, stall_req low, md_rd_wen never asserted. Separately, rd=x0 completes with md_rd_wen=0.
- sys_rst_n low during BUSY: outputs 0 immediately. After release, a new MUL 3×4 yields 12.
